comb_mux8_arbiter: RTL
======================

Name: comb_mux8_arbiter

Overview:
Round-robin scheduler that shares one CombMux8-style 8:1 datapath between eight valid/ready requesters. It drives the select, grants one requester at a time for bounded bursts, and presents the selected word on a registered output with its source index. It sits in front of a Versat unit input that several producers must share.

Parameters:
DATA_W, 32, width of each requester word and of out_data
MAX_BURST, 4, max consecutive transfers per grant (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  8  per-requester valid, bit i = requester i
in_data  input  8*DATA_W  requester i word at [i*DATA_W +: DATA_W]
in_ready  output  8  per-requester accept, one-hot or zero
out_valid  output  1  output word valid
out_data  output  DATA_W  registered selected word
out_sel  output  3  index of requester that produced out_data
out_ready  input  1  downstream accept
busy  output  1  high while in GRANT state

Behaviour:
- Reset values (async, rst=1): out_valid=0, out_data=0, out_sel=0, in_ready=0, busy=0, state=IDLE, grant=0, ptr=0, burst_cnt=0. Reset mid-burst discards any held word; no transfer completes in the reset cycle.
- State IDLE: if in_valid!=0, next grant = first i scanning ptr, ptr+1, ..., ptr+7 (mod 8) with in_valid[i]=1; next state GRANT, burst_cnt<=0. Otherwise stay IDLE. in_ready=0 in IDLE (1-cycle arbitration latency).
- State GRANT: space = !out_valid || out_ready. in_ready[grant] = space (combinational from out_ready); other bits 0. Transfer when in_valid[grant] && in_ready[grant]: out_data<=word of grant, out_sel<=grant, out_valid<=1, burst_cnt<=burst_cnt+1.
- Output register: if out_valid && out_ready && no new transfer, out_valid<=0. Simultaneous drain and new transfer: out_valid stays 1, new word loaded (full throughput, 1 word/cycle in a burst). out_data/out_sel hold while out_valid && !out_ready.
- Grant release (GRANT->IDLE, ptr<=grant+1 mod 8, 7 wraps to 0): (a) transfer occurs and burst_cnt+1==MAX_BURST, or (b) in_valid[grant]=0 in a cycle with space=1. If in_valid[grant]=0 while space=0, grant is held (no release while stalled).
- Requester i may drop in_valid only per valid/ready rules; block never asserts in_ready to a non-granted requester.
- Latency: request in IDLE at cycle t -> in_ready at t+1 -> out_valid at t+2.
- Gap: one IDLE cycle between consecutive grants.
- Fairness: with all 8 requesting continuously, order is 0..7 then wrap, each for MAX_BURST words.
- busy = (state==GRANT).
- out_sel width fixed at 3; ptr and grant are 3-bit, natural mod-8 wrap.

Test Plan:
- Reset, only in_valid[3]=1, in_data[3]=0xA5, out_ready=1 -> in_ready=0x08 one cycle after request, out_valid=1, out_data=0xA5, out_sel=3 two cycles after.
- All in_valid=0xFF, MAX_BURST=2, out_ready=1, data i = i -> out_sel sequence 0,0,1,1,...,7,7,0,0 with one bubble cycle between pairs.
- Requester 5 granted, out_ready=0 for 4 cycles after first word -> out_data/out_sel frozen, in_ready=0, grant held; out_ready=1 resumes burst without data loss or duplication.
- Requester 2 drops in_valid after 1 of 4 burst words while requester 6 valid -> release, ptr=3, next out_sel=6.
- ptr at 7 with in_valid=0x81 -> grant 7 then 0 (wrap), never skip 0.
- Assert rst during burst with out_valid=1 -> immediately out_valid=0, in_ready=0, busy=0; after release, in_valid=0x01 -> grant 0 with ptr=0.

Source files
------------

// File: rtl/comb_mux8_arbiter.sv
// Round-robin scheduler that shares one 8:1 word mux between eight
// valid/ready requesters and drives a registered output stage.
//
// Handshake: a word moves across an interface in any cycle where valid
// and ready are both high at the rising clock edge. A producer holds valid
// and its data stable until that happens. Ready may depend combinationally
// on the consumer's ready, but valid never depends on ready.
module comb_mux8_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Burst counter value at which the next accepted word ends the grant.
  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t            state;
  logic [2:0]        grant;
  logic [2:0]        ptr;
  logic [7:0]        burst_cnt;

  logic [DATA_W-1:0] words [8];
  logic [2:0]        pick;
  logic [2:0]        idx;
  logic              space;
  logic              xfer;
  logic              last_beat;
  logic              release_grant;

  // Unpack the flat requester bus into the 8:1 mux inputs.
  for (genvar g = 0; g < 8; g++) begin : g_unpack
    assign words[g] = in_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester scanning up from ptr with wrap.
  // Scanning from the far end down lets the nearest candidate win last.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (in_valid[idx]) pick = idx;
    end
  end

  // Transfer and release conditions while a requester owns the mux.
  always_comb begin
    space         = !out_valid || out_ready;
    xfer          = (state == GRANT) && in_valid[grant] && space;
    last_beat     = (burst_cnt == LAST_CNT);
    release_grant = (state == GRANT) &&
                    ((xfer && last_beat) || (!in_valid[grant] && space));
  end

  // Only the owning requester ever sees ready, and only when the output
  // register can take a word this cycle.
  always_comb begin
    in_ready = '0;
    if ((state == GRANT) && space) in_ready[grant] = 1'b1;
  end

  assign busy = (state == GRANT);

  // Arbitration FSM: IDLE picks an owner, GRANT runs a bounded burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 3'd0;
      ptr       <= 3'd0;
      burst_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid != 8'd0) begin
            grant     <= pick;
            burst_cnt <= 8'd0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) burst_cnt <= burst_cnt + 8'd1;
          if (release_grant) begin
            state <= IDLE;
            ptr   <= grant + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on transfer, clear on drain, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= words[grant];
      out_sel   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
